// File: rtl/gsensor_spi_sequencer.sv
// ADXL345 3-wire SPI sequencer: power-up wait, three init writes, then periodic
// 6-byte X/Y/Z burst reads published as signed 16-bit samples.
module gsensor_spi_sequencer #(
    parameter int CLK_DIV        = 25,
    parameter int SAMPLE_PERIOD  = 500000,
    parameter int POWERUP_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        spi_sdio_in,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_sdio_out,
    output logic        spi_sdio_oe,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        busy
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int PW = $clog2(POWERUP_CYCLES + 1);
    localparam int SW = $clog2(SAMPLE_PERIOD + 1);
    localparam int GW = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {PWRUP, INIT_WR, WAIT, READ, PUBLISH} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD} phase_t;

    state_t          state;
    phase_t          phase;
    logic [DW-1:0]   dcnt;
    logic [5:0]      bcnt;
    logic [15:0]     tx;
    logic [47:0]     rx;
    logic [1:0]      init_idx;
    logic [PW-1:0]   pwr;
    logic [SW-1:0]   per;
    logic [GW-1:0]   gap;

    logic        div_done, gap_ok, per_full, pwr_done, last_bit, frame_end;
    logic        start_init, start_read, start_frame;
    logic [15:0] init_word, start_word;

    assign div_done   = (dcnt == DW'(CLK_DIV - 1));
    assign gap_ok     = (gap == GW'(2 * CLK_DIV));
    assign per_full   = (per == SW'(SAMPLE_PERIOD));
    assign pwr_done   = (pwr == PW'(POWERUP_CYCLES - 1));
    assign last_bit   = (bcnt == ((state == READ) ? 6'd55 : 6'd15));
    assign frame_end  = !spi_cs_n && (phase == PH_HOLD) && div_done;

    // Init frames go out back to back, separated only by the minimum CS_N gap.
    assign start_init = ((state == PWRUP) && pwr_done) ||
                        ((state == INIT_WR) && spi_cs_n && (init_idx != 2'd3) && gap_ok);
    assign start_read = (state == WAIT) && enable && per_full && gap_ok;
    assign start_frame = start_init || start_read;
    assign start_word  = (state == WAIT) ? 16'hF200 : init_word;

    always_comb begin
        init_word = 16'h2D08;
        case (init_idx)
            2'd0:    init_word = 16'h3140;
            2'd1:    init_word = 16'h2C0A;
            default: init_word = 16'h2D08;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= PWRUP;
            phase        <= PH_SETUP;
            dcnt         <= '0;
            bcnt         <= '0;
            tx           <= '0;
            rx           <= '0;
            init_idx     <= '0;
            pwr          <= '0;
            per          <= '0;
            gap          <= GW'(2 * CLK_DIV);
            spi_sclk     <= 1'b1;
            spi_cs_n     <= 1'b1;
            spi_sdio_out <= 1'b0;
            spi_sdio_oe  <= 1'b0;
            accel_x      <= '0;
            accel_y      <= '0;
            accel_z      <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!gap_ok) gap <= gap + GW'(1);
            if (init_done && !per_full) per <= per + SW'(1);

            if (start_frame) begin
                spi_cs_n     <= 1'b0;
                busy         <= 1'b1;
                spi_sdio_oe  <= 1'b1;
                spi_sdio_out <= 1'b0;
                phase        <= PH_SETUP;
                dcnt         <= '0;
                bcnt         <= '0;
                tx           <= start_word;
            end else if (!spi_cs_n) begin
                dcnt <= div_done ? '0 : dcnt + DW'(1);
                // Read data is captured in the first cycle SCLK is high.
                if (state == READ && phase == PH_HIGH && dcnt == '0 && bcnt >= 6'd8)
                    rx <= {rx[46:0], spi_sdio_in};
                if (div_done) begin
                    case (phase)
                        PH_SETUP: begin
                            spi_sclk     <= 1'b0;
                            spi_sdio_out <= tx[15];
                            tx           <= {tx[14:0], 1'b0};
                            phase        <= PH_LOW;
                        end
                        PH_LOW: begin
                            spi_sclk <= 1'b1;
                            phase    <= PH_HIGH;
                        end
                        PH_HIGH: begin
                            if (last_bit) begin
                                phase <= PH_HOLD;
                            end else begin
                                spi_sclk     <= 1'b0;
                                spi_sdio_out <= tx[15];
                                tx           <= {tx[14:0], 1'b0};
                                bcnt         <= bcnt + 6'd1;
                                phase        <= PH_LOW;
                                if (state == READ && bcnt == 6'd7) spi_sdio_oe <= 1'b0;
                            end
                        end
                        default: begin
                            spi_cs_n     <= 1'b1;
                            busy         <= 1'b0;
                            spi_sdio_oe  <= 1'b0;
                            spi_sdio_out <= 1'b0;
                            gap          <= GW'(1);
                        end
                    endcase
                end
            end

            case (state)
                PWRUP: begin
                    if (!pwr_done) pwr <= pwr + PW'(1);
                    if (start_init) state <= INIT_WR;
                end
                INIT_WR: begin
                    if (frame_end) init_idx <= init_idx + 2'd1;
                    else if (spi_cs_n && init_idx == 2'd3) begin
                        init_done <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (start_read) begin
                        state <= READ;
                        per   <= SW'(1);
                    end
                end
                READ: if (frame_end) state <= PUBLISH;
                PUBLISH: begin
                    // Burst order is X0,X1,Y0,Y1,Z0,Z1; low byte arrives first.
                    accel_x      <= {rx[39:32], rx[47:40]};
                    accel_y      <= {rx[23:16], rx[31:24]};
                    accel_z      <= {rx[7:0],   rx[15:8]};
                    sample_valid <= 1'b1;
                    state        <= WAIT;
                end
                default: state <= PWRUP;
            endcase
        end
    end
endmodule
